turbo_frame_sched: RTL

Frame scheduler for the turbo encoder output stage. It captures one frame of serial systematic, RSC1 parity and RSC2 parity bits in parallel. It then places the three streams as 4-bit nibbles on a single shared output bus in interleaved order (sys, p1, p2 per nibble index) under valid/ready flow control. It sits between the constituent RSC encoders and the downstream nibble consumer, replacing free-running per-stream serial-to-parallel converters.

---
 rtl/turbo_frame_sched_if.sv | 32 +++
 rtl/turbo_frame_sched.sv | 138 +++++++++++++
 2 files changed

// File: rtl/turbo_frame_sched_if.sv
// Handshake and bus bundle for turbo_frame_sched: serial capture inputs plus the
// shared interleaved nibble output stream and status pulses.
interface turbo_frame_sched_if #(
    parameter int IDX_W = 4
);
    logic             i_start;
    logic             i_bit_valid;
    logic             i_sys_in;
    logic             i_p1_in;
    logic             i_p2_in;
    logic             i_out_ready;
    logic             o_out_valid;
    logic [3:0]       o_out_data;
    logic [1:0]       o_out_sel;
    logic [IDX_W-1:0] o_out_idx;
    logic             o_out_last;
    logic             o_busy;
    logic             o_done;
    logic             o_start_drop;

    modport slave (
        input  i_start, i_bit_valid, i_sys_in, i_p1_in, i_p2_in, i_out_ready,
        output o_out_valid, o_out_data, o_out_sel, o_out_idx, o_out_last,
               o_busy, o_done, o_start_drop
    );

    modport master (
        output i_start, i_bit_valid, i_sys_in, i_p1_in, i_p2_in, i_out_ready,
        input  o_out_valid, o_out_data, o_out_sel, o_out_idx, o_out_last,
               o_busy, o_done, o_start_drop
    );
endinterface

// File: rtl/turbo_frame_sched.sv
// Turbo encoder output-stage frame scheduler: captures one frame of sys/p1/p2
// serial bits, then emits them as interleaved nibbles under valid/ready.
module turbo_frame_sched #(
    parameter int FRAME_BITS = 64,
    parameter int IDX_W      = 4
) (
    input logic                 clk,
    input logic                 rst,
    turbo_frame_sched_if.slave  io
);
    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(FRAME_BITS / 4 - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN
    } state_t;

    state_t                  r_state;
    logic [FRAME_BITS-1:0]   r_sysBuf;
    logic [FRAME_BITS-1:0]   r_p1Buf;
    logic [FRAME_BITS-1:0]   r_p2Buf;
    logic [CNT_W-1:0]        r_bitCnt;
    logic                    r_outValid;
    logic [3:0]              r_outData;
    logic [1:0]              r_outSel;
    logic [IDX_W-1:0]        r_outIdx;
    logic                    r_outLast;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_startDrop;

    logic [1:0]              w_advSel;
    logic [IDX_W-1:0]        w_advIdx;
    logic [FRAME_BITS-1:0]   w_selBuf;
    logic [IDX_W+1:0]        w_base;
    logic [3:0]              w_advNibble;
    logic [FRAME_BITS-1:0]   w_loadSys;
    logic                    w_handshake;

    // Next position in the sys,p1,p2-per-index interleave and the nibble it names.
    // Buffers are frozen during DRAIN, so the lookup can be done one step ahead.
    always_comb begin
        w_advSel = r_outSel + 2'd1;
        w_advIdx = r_outIdx;
        if (r_outSel == 2'd2) begin
            w_advSel = 2'd0;
            w_advIdx = r_outIdx + IDX_W'(1);
        end
        case (w_advSel)
            2'd0:    w_selBuf = r_sysBuf;
            2'd1:    w_selBuf = r_p1Buf;
            default: w_selBuf = r_p2Buf;
        endcase
        w_base      = (IDX_W+2)'(FRAME_BITS - 1) - {w_advIdx, 2'b00};
        w_advNibble = w_selBuf[w_base -: 4];
    end

    assign w_loadSys   = {r_sysBuf[FRAME_BITS-2:0], io.i_sys_in};
    assign w_handshake = r_outValid & io.i_out_ready;

    // Single FSM with all outputs registered; the first nibble is taken from the
    // incoming shift value so out_valid rises right after the final captured bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sysBuf    <= '0;
            r_p1Buf     <= '0;
            r_p2Buf     <= '0;
            r_bitCnt    <= '0;
            r_outValid  <= 1'b0;
            r_outData   <= 4'd0;
            r_outSel    <= 2'd0;
            r_outIdx    <= '0;
            r_outLast   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_startDrop <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_startDrop <= io.i_start && (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    if (io.i_start) begin
                        r_state  <= LOAD;
                        r_bitCnt <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                LOAD: begin
                    if (io.i_bit_valid) begin
                        r_sysBuf <= w_loadSys;
                        r_p1Buf  <= {r_p1Buf[FRAME_BITS-2:0], io.i_p1_in};
                        r_p2Buf  <= {r_p2Buf[FRAME_BITS-2:0], io.i_p2_in};
                        r_bitCnt <= r_bitCnt + CNT_W'(1);
                        if (r_bitCnt == CNT_W'(FRAME_BITS - 1)) begin
                            r_state    <= DRAIN;
                            r_outValid <= 1'b1;
                            r_outData  <= w_loadSys[FRAME_BITS-1 -: 4];
                            r_outSel   <= 2'd0;
                            r_outIdx   <= '0;
                            r_outLast  <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (w_handshake) begin
                        if (r_outLast) begin
                            r_state    <= IDLE;
                            r_outValid <= 1'b0;
                            r_outLast  <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                        end else begin
                            r_outSel  <= w_advSel;
                            r_outIdx  <= w_advIdx;
                            r_outData <= w_advNibble;
                            r_outLast <= (w_advSel == 2'd2) && (w_advIdx == MAX_IDX);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign io.o_out_valid  = r_outValid;
    assign io.o_out_data   = r_outData;
    assign io.o_out_sel    = r_outSel;
    assign io.o_out_idx    = r_outIdx;
    assign io.o_out_last   = r_outLast;
    assign io.o_busy       = r_busy;
    assign io.o_done       = r_done;
    assign io.o_start_drop = r_startDrop;
endmodule
